// File: rtl/tlul_host_arb_if.sv
// TL-UL request/response structs plus the bundle that carries every host and
// device channel into the arbiter.
package tlul_pkg;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [15:0] a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [15:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   localparam logic [2:0] OpGet       = 3'h4;
   localparam logic [2:0] OpAccessAck = 3'h0;

   localparam tl_h2d_t TL_H2D_DEFAULT = '{
      a_valid:   1'b0,
      a_opcode:  OpGet,
      a_param:   3'h0,
      a_size:    2'h0,
      a_source:  8'h0,
      a_address: 32'h0,
      a_mask:    4'h0,
      a_data:    32'h0,
      a_user:    16'h0,
      d_ready:   1'b1
   };

   localparam tl_d2h_t TL_D2H_DEFAULT = '{
      d_valid:  1'b0,
      d_opcode: OpAccessAck,
      d_param:  3'h0,
      d_size:   2'h0,
      d_source: 8'h0,
      d_sink:   1'b0,
      d_data:   32'h0,
      d_user:   16'h0,
      d_error:  1'b0,
      a_ready:  1'b1
   };

endpackage

interface tlul_host_arb_if
   import tlul_pkg::*;
#(
   parameter int NumHosts = 2
);
   tl_h2d_t [NumHosts-1:0] tl_h_i;
   tl_d2h_t [NumHosts-1:0] tl_h_o;
   tl_h2d_t                tl_d_o;
   tl_d2h_t                tl_d_i;

   modport slave  (input  tl_h_i, tl_d_i, output tl_h_o, tl_d_o);
   modport master (output tl_h_i, tl_d_i, input  tl_h_o, tl_d_o);
endinterface

// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one in-order TL-UL device between NumHosts hosts;
// an in-order FIFO of grant indices steers each D response back to its host.
module tlul_host_arb
   import tlul_pkg::*;
#(
   parameter  int NumHosts       = 2,
   parameter  int MaxOutstanding = 4,
   localparam int IdxW           = (NumHosts > 1) ? $clog2(NumHosts) : 1,
   localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   tlul_host_arb_if.slave  bus,
   output logic [CntW-1:0] outstanding_o,
   output logic            busy_o,
   output logic            spurious_rsp_o
);

   localparam int              PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutstanding);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(MaxOutstanding - 1);
   localparam int              PayloadW = $bits(tl_h2d_t) - 2;

   logic [IdxW-1:0] rr_q, rr_d;
   logic            lock_q, lock_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic [IdxW-1:0] fifo_q [MaxOutstanding];
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            spurious_q, spurious_d;

   logic                grantValid;
   logic [IdxW-1:0]     grantIdx;
   logic [NumHosts-1:0] grantVec;
   logic                grantAValid;
   logic                full, empty;
   logic                aValidOut, aHandshake;
   logic [IdxW-1:0]     headIdx;
   logic                dReadyOut, dHandshake, pop;
   logic [PayloadW-1:0] aPayload;

   function automatic logic [IdxW-1:0] wrapIdx(input logic [IdxW-1:0] base,
                                               input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= 32'(NumHosts)) sum = sum - 32'(NumHosts);
      return IdxW'(sum);
   endfunction

   // A held lock wins outright; otherwise the lowest offset from rr_q wins,
   // so the loop walks offsets high to low and the last hit is kept.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      if (lock_q) begin
         grantValid = 1'b1;
         grantIdx   = lock_idx_q;
      end else begin
         for (int k = NumHosts - 1; k >= 0; k--) begin
            if (bus.tl_h_i[wrapIdx(rr_q, k)].a_valid) begin
               grantValid = 1'b1;
               grantIdx   = wrapIdx(rr_q, k);
            end
         end
      end
      grantVec = grantValid ? (NumHosts'(1) << grantIdx) : '0;
   end

   assign full        = (cnt_q == MaxCnt);
   assign empty       = (cnt_q == '0);
   assign grantAValid = grantValid && bus.tl_h_i[grantIdx].a_valid;
   assign aValidOut   = rst_ni && grantAValid && !full;
   assign aHandshake  = aValidOut && bus.tl_d_i.a_ready;
   assign headIdx     = fifo_q[rptr_q];
   assign dReadyOut   = empty ? 1'b1 : bus.tl_h_i[headIdx].d_ready;
   assign dHandshake  = bus.tl_d_i.d_valid && dReadyOut;
   assign pop         = dHandshake && !empty;

   // Device request: the granted host's fields pass straight through, while
   // d_ready always follows whichever host owns the oldest outstanding request.
   always_comb begin
      bus.tl_d_o = TL_H2D_DEFAULT;
      if (grantValid) bus.tl_d_o = bus.tl_h_i[grantIdx];
      bus.tl_d_o.a_valid = aValidOut;
      bus.tl_d_o.d_ready = dReadyOut;
   end

   always_comb begin
      busy_o = (cnt_q != '0);
      for (int i = 0; i < NumHosts; i++) begin
         bus.tl_h_o[i] = TL_D2H_DEFAULT;
         bus.tl_h_o[i].d_valid = 1'b0;
         if (!empty && (headIdx == IdxW'(i))) bus.tl_h_o[i] = bus.tl_d_i;
         bus.tl_h_o[i].a_ready = rst_ni && grantValid && (grantIdx == IdxW'(i))
                                 && bus.tl_d_i.a_ready && !full;
         busy_o = busy_o || bus.tl_h_i[i].a_valid;
      end
   end

   // Next-state: a stalled grant locks the port until its A handshake.
   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      spurious_d = spurious_q;
      cnt_d      = cnt_q + CntW'(aHandshake) - CntW'(pop);
      if (aHandshake) begin
         rr_d   = wrapIdx(grantIdx, 1);
         wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
         lock_d = 1'b0;
      end else if (grantAValid) begin
         lock_d     = 1'b1;
         lock_idx_d = grantIdx;
      end
      if (pop) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      if (bus.tl_d_i.d_valid && empty) spurious_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         spurious_q <= 1'b0;
         for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         spurious_q <= spurious_d;
         if (aHandshake) fifo_q[wptr_q] <= grantIdx;
      end
   end

   assign outstanding_o  = cnt_q;
   assign spurious_rsp_o = spurious_q;

   assign aPayload = {bus.tl_d_o.a_opcode, bus.tl_d_o.a_param, bus.tl_d_o.a_size,
                      bus.tl_d_o.a_source, bus.tl_d_o.a_address, bus.tl_d_o.a_mask,
                      bus.tl_d_o.a_data, bus.tl_d_o.a_user};

   grantOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(grantVec));
   lockPayloadStable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      lock_q |-> $stable(aPayload));
   popNotEmpty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      dHandshake && !empty |-> cnt_q != '0);
   pushNotFull: assert property (@(posedge clk_i) disable iff (!rst_ni)
      aHandshake |-> cnt_q < MaxCnt);
   cntInRange: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q <= MaxCnt);

endmodule

// File: tb/tb_tlul_host_arb.sv
// Scenario bench for tlul_host_arb: each request pushes its expected response
// onto a scoreboard that is popped as responses reach the hosts.
module tb_tlul_host_arb;
   import tlul_pkg::*;

   localparam int NH = 2;
   localparam int MO = 4;
   localparam int CW = $clog2(MO + 1);

   typedef struct {
      int          host;
      logic [31:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] outstanding;
   logic          busy;
   logic          spurious;

   int          testsRun    = 0;
   int          testsFailed = 0;
   exp_t        expQ[$];
   logic [31:0] devQ[$];
   logic [31:0] hostAddr[NH];

   always #5 clk = ~clk;

   tlul_host_arb_if #(.NumHosts(NH)) bus ();

   tlul_host_arb #(
      .NumHosts       (NH),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .bus            (bus),
      .outstanding_o  (outstanding),
      .busy_o         (busy),
      .spurious_rsp_o (spurious)
   );

   function automatic logic [31:0] rspFn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic clearInputs();
      for (int h = 0; h < NH; h++) begin
         bus.tl_h_i[h]          = '0;
         bus.tl_h_i[h].a_opcode = OpGet;
         bus.tl_h_i[h].a_mask   = 4'hF;
         bus.tl_h_i[h].d_ready  = 1'b1;
      end
      bus.tl_d_i = '0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      clearInputs();
      expQ.delete();
      devQ.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Device model: answers in order, one cycle after each accepted request.
   task automatic devDrive(input bit rspEn);
      bus.tl_d_i.d_valid = rspEn && (devQ.size() > 0);
      bus.tl_d_i.d_data  = (devQ.size() > 0) ? devQ[0] : 32'h0;
   endtask

   task automatic devSample();
      if (bus.tl_d_i.d_valid && bus.tl_d_o.d_ready && devQ.size() > 0) void'(devQ.pop_front());
      if (bus.tl_d_o.a_valid && bus.tl_d_i.a_ready) devQ.push_back(rspFn(bus.tl_d_o.a_address));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clearInputs();
      for (int h = 0; h < NH; h++) bus.tl_h_i[h].a_valid = 1'b1;
      bus.tl_d_i.a_ready = 1'b1;
      bus.tl_d_i.d_valid = 1'b1;
      @(negedge clk);
      testsRun++;
      if (bus.tl_d_o.a_valid !== 1'b0 || outstanding !== '0 || spurious !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: a_valid=%b outstanding=%0d spurious=%b, expected 0/0/0",
                  bus.tl_d_o.a_valid, outstanding, spurious);
      end
      for (int h = 0; h < NH; h++) begin
         testsRun++;
         if (bus.tl_h_o[h].a_ready !== 1'b0 || bus.tl_h_o[h].d_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_host%0d: a_ready=%b d_valid=%b, expected 0/0",
                     h, bus.tl_h_o[h].a_ready, bus.tl_h_o[h].d_valid);
         end
      end
      clearInputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      testsRun++;
      if (busy !== 1'b0 || outstanding !== '0 || spurious !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_idle: busy=%b outstanding=%0d spurious=%b, expected 0/0/0",
                  busy, outstanding, spurious);
      end
   endtask

   task automatic test_round_robin();
      int   expGrant = 0;
      int   peak     = 0;
      exp_t e;
      applyReset();
      for (int h = 0; h < NH; h++) hostAddr[h] = 32'h1000_0000 * (h + 1);
      bus.tl_d_i.a_ready = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         for (int h = 0; h < NH; h++) begin
            bus.tl_h_i[h].a_valid   = (cyc < 8);
            bus.tl_h_i[h].a_address = hostAddr[h];
         end
         devDrive(1'b1);
         @(negedge clk);
         for (int h = 0; h < NH; h++) begin
            if (bus.tl_h_o[h].d_valid === 1'b1) begin
               testsRun++;
               if (expQ.size() == 0) begin
                  testsFailed++;
                  $display("[TB] FAIL rr_route: host %0d got d_data=%h, none expected", h, bus.tl_h_o[h].d_data);
               end else begin
                  e = expQ.pop_front();
                  if (e.host != h || bus.tl_h_o[h].d_data !== e.data) begin
                     testsFailed++;
                     $display("[TB] FAIL rr_route: host %0d data %h, expected host %0d data %h",
                              h, bus.tl_h_o[h].d_data, e.host, e.data);
                  end
               end
            end
         end
         if (cyc < 8) begin
            testsRun++;
            if (bus.tl_h_o[expGrant].a_ready !== 1'b1 || bus.tl_d_o.a_address !== hostAddr[expGrant]) begin
               testsFailed++;
               $display("[TB] FAIL rr_grant cyc %0d: a_ready=%b addr=%h, expected host %0d addr %h",
                        cyc, bus.tl_h_o[expGrant].a_ready, bus.tl_d_o.a_address, expGrant, hostAddr[expGrant]);
            end
            e.host = expGrant;
            e.data = rspFn(hostAddr[expGrant]);
            expQ.push_back(e);
         end
         if (int'(outstanding) > peak) peak = int'(outstanding);
         devSample();
         @(posedge clk);
         #1;
         if (cyc < 8) begin
            hostAddr[expGrant] += 32'h4;
            expGrant = (expGrant + 1) % NH;
         end
      end
      if (int'(outstanding) > peak) peak = int'(outstanding);
      testsRun++;
      if (expQ.size() != 0 || outstanding !== '0 || peak != 1) begin
         testsFailed++;
         $display("[TB] FAIL rr_drain: left=%0d outstanding=%0d peak=%0d, expected 0/0/1",
                  expQ.size(), outstanding, peak);
      end
   endtask

   task automatic test_lock();
      int   expG;
      exp_t e;
      applyReset();
      hostAddr[0] = 32'h2000_0000;
      hostAddr[1] = 32'h3000_0040;
      for (int cyc = 0; cyc < 9; cyc++) begin
         bus.tl_h_i[1].a_valid   = (cyc <= 5);
         bus.tl_h_i[1].a_address = hostAddr[1];
         bus.tl_h_i[0].a_valid   = (cyc >= 2 && cyc <= 6);
         bus.tl_h_i[0].a_address = hostAddr[0];
         bus.tl_d_i.a_ready      = (cyc >= 5);
         devDrive(1'b1);
         @(negedge clk);
         for (int h = 0; h < NH; h++) begin
            if (bus.tl_h_o[h].d_valid === 1'b1) begin
               testsRun++;
               if (expQ.size() == 0) begin
                  testsFailed++;
                  $display("[TB] FAIL lock_route: host %0d got d_data=%h, none expected", h, bus.tl_h_o[h].d_data);
               end else begin
                  e = expQ.pop_front();
                  if (e.host != h || bus.tl_h_o[h].d_data !== e.data) begin
                     testsFailed++;
                     $display("[TB] FAIL lock_route: host %0d data %h, expected host %0d data %h",
                              h, bus.tl_h_o[h].d_data, e.host, e.data);
                  end
               end
            end
         end
         if (cyc <= 6) begin
            expG = (cyc <= 5) ? 1 : 0;
            testsRun++;
            if (bus.tl_d_o.a_valid !== 1'b1 || bus.tl_d_o.a_address !== hostAddr[expG]
                || bus.tl_h_o[expG].a_ready !== (cyc >= 5) || bus.tl_h_o[1 - expG].a_ready !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL lock_grant cyc %0d: a_valid=%b addr=%h rdy0=%b rdy1=%b, expected host %0d addr %h",
                        cyc, bus.tl_d_o.a_valid, bus.tl_d_o.a_address,
                        bus.tl_h_o[0].a_ready, bus.tl_h_o[1].a_ready, expG, hostAddr[expG]);
            end
            if (cyc >= 5) begin
               e.host = expG;
               e.data = rspFn(hostAddr[expG]);
               expQ.push_back(e);
            end
         end
         devSample();
         @(posedge clk);
         #1;
      end
      testsRun++;
      if (expQ.size() != 0 || outstanding !== '0) begin
         testsFailed++;
         $display("[TB] FAIL lock_drain: left=%0d outstanding=%0d, expected 0/0", expQ.size(), outstanding);
      end
   endtask

   task automatic test_full();
      int   accepted = 0;
      bit   took;
      exp_t e;
      applyReset();
      hostAddr[0] = 32'h4000_0000;
      bus.tl_d_i.a_ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         bus.tl_h_i[0].a_valid   = 1'b1;
         bus.tl_h_i[0].a_address = hostAddr[0];
         devDrive(1'b0);
         @(negedge clk);
         took = bus.tl_d_o.a_valid && bus.tl_d_i.a_ready;
         if (took) begin
            accepted++;
            e.host = 0;
            e.data = rspFn(hostAddr[0]);
            expQ.push_back(e);
         end
         devSample();
         @(posedge clk);
         #1;
         if (took) hostAddr[0] += 32'h4;
      end
      testsRun++;
      if (accepted != MO || bus.tl_d_o.a_valid !== 1'b0 || outstanding !== CW'(MO)
          || busy !== 1'b1 || bus.tl_h_o[0].a_ready !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL full_block: accepted=%0d a_valid=%b outstanding=%0d busy=%b a_ready=%b, expected %0d/0/%0d/1/0",
                  accepted, bus.tl_d_o.a_valid, outstanding, busy, bus.tl_h_o[0].a_ready, MO, MO);
      end
      devDrive(1'b1);
      @(negedge clk);
      testsRun++;
      if (bus.tl_d_o.a_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL full_same_cycle_pop: a_valid=%b, expected 0", bus.tl_d_o.a_valid);
      end
      e = expQ.pop_front();
      testsRun++;
      if (bus.tl_h_o[0].d_valid !== 1'b1 || bus.tl_h_o[0].d_data !== e.data) begin
         testsFailed++;
         $display("[TB] FAIL full_rsp: d_valid=%b data=%h, expected 1 data %h",
                  bus.tl_h_o[0].d_valid, bus.tl_h_o[0].d_data, e.data);
      end
      devSample();
      @(posedge clk);
      #1;
      devDrive(1'b0);
      @(negedge clk);
      testsRun++;
      if (outstanding !== CW'(MO - 1) || bus.tl_d_o.a_valid !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL full_reopen: outstanding=%0d a_valid=%b, expected %0d/1",
                  outstanding, bus.tl_d_o.a_valid, MO - 1);
      end
      devSample();
      @(posedge clk);
      #1;
      testsRun++;
      if (outstanding !== CW'(MO)) begin
         testsFailed++;
         $display("[TB] FAIL full_refill: outstanding=%0d, expected %0d", outstanding, MO);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      applyReset();
      hostAddr[0] = 32'h5000_0000;
      hostAddr[1] = 32'h6000_0000;
      bus.tl_d_i.a_ready = 1'b1;
      for (int cyc = 0; cyc < 2; cyc++) begin
         bus.tl_h_i[0].a_valid   = 1'b1;
         bus.tl_h_i[0].a_address = hostAddr[0];
         devDrive(1'b0);
         @(negedge clk);
         testsRun++;
         if (bus.tl_h_o[0].a_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_fill cyc %0d: host0 a_ready=%b, expected 1", cyc, bus.tl_h_o[0].a_ready);
         end
         e.host = 0;
         e.data = rspFn(hostAddr[0]);
         expQ.push_back(e);
         devSample();
         @(posedge clk);
         #1;
         hostAddr[0] += 32'h4;
      end
      bus.tl_h_i[0].a_valid   = 1'b0;
      bus.tl_h_i[1].a_valid   = 1'b1;
      bus.tl_h_i[1].a_address = hostAddr[1];
      devDrive(1'b1);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outstanding !== CW'(2) || bus.tl_h_o[1].a_ready !== 1'b1 || bus.tl_h_o[1].d_valid !== 1'b0
          || bus.tl_h_o[0].d_valid !== 1'b1 || bus.tl_h_o[0].d_data !== e.data) begin
         testsFailed++;
         $display("[TB] FAIL b2b_pushpop: cnt=%0d rdy1=%b dv0=%b dv1=%b data0=%h, expected 2/1/1/0 data %h",
                  outstanding, bus.tl_h_o[1].a_ready, bus.tl_h_o[0].d_valid,
                  bus.tl_h_o[1].d_valid, bus.tl_h_o[0].d_data, e.data);
      end
      devSample();
      @(posedge clk);
      #1;
      bus.tl_h_i[1].a_valid = 1'b0;
      devDrive(1'b0);
      @(negedge clk);
      testsRun++;
      if (outstanding !== CW'(2)) begin
         testsFailed++;
         $display("[TB] FAIL b2b_count: outstanding=%0d, expected 2", outstanding);
      end
   endtask

   task automatic test_spurious();
      applyReset();
      bus.tl_d_i.d_valid = 1'b1;
      bus.tl_d_i.d_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      testsRun++;
      if (bus.tl_d_o.d_ready !== 1'b1 || bus.tl_h_o[0].d_valid !== 1'b0 || bus.tl_h_o[1].d_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL spur_drain: d_ready=%b dv0=%b dv1=%b, expected 1/0/0",
                  bus.tl_d_o.d_ready, bus.tl_h_o[0].d_valid, bus.tl_h_o[1].d_valid);
      end
      @(posedge clk);
      #1;
      bus.tl_d_i.d_valid = 1'b0;
      testsRun++;
      if (spurious !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL spur_set: spurious=%b, expected 1", spurious);
      end
      repeat (3) @(posedge clk);
      #1;
      testsRun++;
      if (spurious !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL spur_sticky: spurious=%b, expected 1", spurious);
      end
      #2;
      rst_n = 1'b0;
      #1;
      testsRun++;
      if (spurious !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL spur_clear: spurious=%b, expected 0", spurious);
      end
   endtask

   task automatic test_reset_mid();
      applyReset();
      hostAddr[0] = 32'h7000_0000;
      hostAddr[1] = 32'h7800_0000;
      bus.tl_d_i.a_ready = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         bus.tl_h_i[0].a_valid   = 1'b1;
         bus.tl_h_i[0].a_address = hostAddr[0];
         @(posedge clk);
         #1;
         hostAddr[0] += 32'h4;
      end
      bus.tl_h_i[0].a_valid = 1'b0;
      testsRun++;
      if (outstanding !== CW'(3)) begin
         testsFailed++;
         $display("[TB] FAIL mid_fill: outstanding=%0d, expected 3", outstanding);
      end
      for (int h = 0; h < NH; h++) begin
         bus.tl_h_i[h].a_valid   = 1'b1;
         bus.tl_h_i[h].a_address = hostAddr[h];
      end
      bus.tl_d_i.d_valid = 1'b1;
      bus.tl_d_i.d_data  = 32'h1234_5678;
      #2;
      rst_n = 1'b0;
      #1;
      testsRun++;
      if (outstanding !== '0 || spurious !== 1'b0 || bus.tl_d_o.a_valid !== 1'b0
          || bus.tl_h_o[0].a_ready !== 1'b0 || bus.tl_h_o[1].a_ready !== 1'b0
          || bus.tl_h_o[0].d_valid !== 1'b0 || bus.tl_h_o[1].d_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL mid_reset: cnt=%0d spur=%b av=%b rdy=%b%b dv=%b%b, expected all 0",
                  outstanding, spurious, bus.tl_d_o.a_valid, bus.tl_h_o[0].a_ready,
                  bus.tl_h_o[1].a_ready, bus.tl_h_o[0].d_valid, bus.tl_h_o[1].d_valid);
      end
      bus.tl_d_i.d_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      testsRun++;
      if (bus.tl_h_o[0].a_ready !== 1'b1 || bus.tl_h_o[1].a_ready !== 1'b0
          || bus.tl_d_o.a_address !== hostAddr[0]) begin
         testsFailed++;
         $display("[TB] FAIL mid_first_grant: rdy0=%b rdy1=%b addr=%h, expected 1/0 addr %h",
                  bus.tl_h_o[0].a_ready, bus.tl_h_o[1].a_ready, bus.tl_d_o.a_address, hostAddr[0]);
      end
      clearInputs();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clearInputs();
      test_reset();
      test_round_robin();
      test_lock();
      test_full();
      test_back_to_back();
      test_spurious();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
